// File: rtl/key_entry_sequencer_if.sv
// Key-entry sequencer bus: keypad strobe and CPU status in,
// operands, operator and sequencing controls out.
interface key_entry_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  key_valid;
  logic [7:0]            key_code;
  logic                  cpu_done;
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [7:0]            operator;
  logic                  assembler_en;
  logic                  cu_en;
  logic                  soft_reset;
  logic                  key_error;
  logic [2:0]            seq_state;

  modport master (
    output key_valid, key_code, cpu_done,
    input  operand1, operand2, operator,
    input  assembler_en, cu_en, soft_reset,
    input  key_error, seq_state
  );

  modport slave (
    input  key_valid, key_code, cpu_done,
    output operand1, operand2, operator,
    output assembler_en, cu_en, soft_reset,
    output key_error, seq_state
  );
endinterface

// File: rtl/key_entry_sequencer.sv
// Event-driven keypad parser: builds two decimal operands and an
// operator, then sequences the assembler window and the CPU run.
// Ports: clock, globalReset_n (async, active-low), bus (slave):
//   key_valid/key_code/cpu_done in; operand1/operand2/operator,
//   assembler_en, cu_en, soft_reset, key_error, seq_state out.
// Option: define KEY_ENTRY_TIMEOUT_EN to abort RUN after
//   RUN_TIMEOUT clocks without cpu_done.
module key_entry_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_DIGITS  = 2,
  parameter int ASM_CYCLES  = 4,
  parameter int RUN_TIMEOUT = 1000000
) (
  input logic                  clock,
  input logic                  globalReset_n,
  key_entry_sequencer_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int AW = (ASM_CYCLES > 1) ? $clog2(ASM_CYCLES) : 1;
  localparam int PW = DATA_WIDTH + 4;

  localparam logic [CW-1:0] CMAX  = CW'(MAX_DIGITS);
  localparam logic [AW-1:0] ALAST = AW'(ASM_CYCLES - 1);
  localparam logic [PW-1:0] SAT   = {4'b0, {DATA_WIDTH{1'b1}}};

  if (MAX_DIGITS < 1) begin : g_bad_digits
    $error("MAX_DIGITS must be >= 1");
  end
  if (ASM_CYCLES < 1) begin : g_bad_asm
    $error("ASM_CYCLES must be >= 1");
  end
  if (RUN_TIMEOUT < 1) begin : g_bad_tmo
    $error("RUN_TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    OP1   = 3'd0,
    OP2   = 3'd1,
    ASM   = 3'd2,
    READY = 3'd3,
    RUN   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [7:0]            oper_q, oper_d;
  logic [CW-1:0]         cnt1_q, cnt1_d;
  logic [CW-1:0]         cnt2_q, cnt2_d;
  logic [AW-1:0]         asm_cnt_q, asm_cnt_d;
  logic                  asm_en_q, asm_en_d;
  logic                  cu_en_q, cu_en_d;
  logic                  sr_q, sr_d;
  logic                  err_q, err_d;
  logic                  done_q, done_p_q;

`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(RUN_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(RUN_TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic is_digit, is_oper, is_enter, is_eq, is_clr;
  assign is_digit = bus.key_code <= 8'd9;
  assign is_oper  = (bus.key_code >= 8'd20) &&
                    (bus.key_code <= 8'd23);
  assign is_enter = bus.key_code == 8'd26;
  assign is_eq    = bus.key_code == 8'd27;
  assign is_clr   = bus.key_code == 8'd28;

  logic rise;
  assign rise = done_q & ~done_p_q;

  // Active operand accumulator; a zero digit count means the
  // operand restarts from 0 (retained display values are dropped).
  logic                  in_op2;
  logic [CW-1:0]         cnt_cur;
  logic [DATA_WIDTH-1:0] acc_cur;
  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] acc_new;

  assign in_op2  = state_q == OP2;
  assign cnt_cur = in_op2 ? cnt2_q : cnt1_q;
  assign acc_cur = (cnt_cur == '0) ? '0 :
                   (in_op2 ? op2_q : op1_q);
  assign prod    = PW'(acc_cur) * PW'(10) +
                   PW'(bus.key_code[3:0]);
  assign acc_new = (prod > SAT) ? {DATA_WIDTH{1'b1}} :
                   prod[DATA_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    oper_d    = oper_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    asm_cnt_d = asm_cnt_q;
    asm_en_d  = asm_en_q;
    cu_en_d   = cu_en_q;
    sr_d      = 1'b0;
    err_d     = 1'b0;
`ifdef KEY_ENTRY_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    if (bus.key_valid && is_clr) begin
      state_d   = OP1;
      op1_d     = '0;
      op2_d     = '0;
      oper_d    = '0;
      cnt1_d    = '0;
      cnt2_d    = '0;
      asm_cnt_d = '0;
      asm_en_d  = 1'b0;
      cu_en_d   = 1'b0;
      sr_d      = 1'b1;
`ifdef KEY_ENTRY_TIMEOUT_EN
      tmo_d     = '0;
`endif
    end else begin
      unique case (state_q)
        ASM: begin
          err_d     = bus.key_valid;
          asm_cnt_d = asm_cnt_q + AW'(1);
          if (asm_cnt_q == ALAST) begin
            asm_cnt_d = '0;
            asm_en_d  = 1'b0;
            state_d   = READY;
          end
        end
        RUN: begin
          err_d = bus.key_valid;
          if (rise) begin
            cu_en_d = 1'b0;
            cnt1_d  = '0;
            cnt2_d  = '0;
            state_d = OP1;
          end
`ifdef KEY_ENTRY_TIMEOUT_EN
          else if (tmo_q == TLAST) begin
            cu_en_d = 1'b0;
            err_d   = 1'b1;
            cnt1_d  = '0;
            cnt2_d  = '0;
            state_d = OP1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
`endif
        end
        default: begin
          if (bus.key_valid) begin
            unique case (1'b1)
              is_digit: begin
                if (state_q == READY ||
                    cnt_cur == CMAX) begin
                  err_d = 1'b1;
                end else if (in_op2) begin
                  op2_d  = acc_new;
                  cnt2_d = cnt2_q + CW'(1);
                end else begin
                  op1_d  = acc_new;
                  cnt1_d = cnt1_q + CW'(1);
                  if (cnt1_q == '0) begin
                    op2_d  = '0;
                    oper_d = '0;
                  end
                end
              end
              is_oper: begin
                if (state_q == OP1 && cnt1_q != '0) begin
                  oper_d  = bus.key_code;
                  state_d = OP2;
                end else if (in_op2 && cnt2_q == '0) begin
                  oper_d = bus.key_code;
                end else begin
                  err_d = 1'b1;
                end
              end
              is_enter: begin
                if (in_op2 && cnt2_q != '0) begin
                  asm_en_d  = 1'b1;
                  asm_cnt_d = '0;
                  state_d   = ASM;
                end else begin
                  err_d = 1'b1;
                end
              end
              is_eq: begin
                if (state_q == READY) begin
                  cu_en_d = 1'b1;
                  state_d = RUN;
`ifdef KEY_ENTRY_TIMEOUT_EN
                  tmo_d   = '0;
`endif
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      state_q   <= OP1;
      op1_q     <= '0;
      op2_q     <= '0;
      oper_q    <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      asm_cnt_q <= '0;
      asm_en_q  <= 1'b0;
      cu_en_q   <= 1'b0;
      sr_q      <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      done_p_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      oper_q    <= oper_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      asm_cnt_q <= asm_cnt_d;
      asm_en_q  <= asm_en_d;
      cu_en_q   <= cu_en_d;
      sr_q      <= sr_d;
      err_q     <= err_d;
      done_q    <= bus.cpu_done;
      done_p_q  <= done_q;
    end
  end

`ifdef KEY_ENTRY_TIMEOUT_EN
  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) tmo_q <= '0;
    else                tmo_q <= tmo_d;
  end
`endif

  assign bus.operand1     = op1_q;
  assign bus.operand2     = op2_q;
  assign bus.operator     = oper_q;
  assign bus.assembler_en = asm_en_q;
  assign bus.cu_en        = cu_en_q;
  assign bus.soft_reset   = sr_q;
  assign bus.key_error    = err_q;
  assign bus.seq_state    = state_q;
endmodule

// File: tb/tb_key_entry_sequencer.sv
// Self-checking bench for key_entry_sequencer: vector table,
// corner sequences and a randomized run against a reference model.
module tb_key_entry_sequencer;
  localparam int W    = 8;
  localparam int MAXD = 2;
  localparam int ASMC = 4;
  localparam int RUNT = 16;
  localparam int MAXV = (1 << W) - 1;

  logic clock = 1'b0;
  logic globalReset_n = 1'b0;
  always #10 clock = ~clock;

  key_entry_sequencer_if #(.DATA_WIDTH(W)) ifa ();
  key_entry_sequencer_if #(.DATA_WIDTH(W)) ifb ();

  key_entry_sequencer #(
    .DATA_WIDTH(W), .MAX_DIGITS(MAXD),
    .ASM_CYCLES(ASMC), .RUN_TIMEOUT(RUNT)
  ) dut (
    .clock(clock), .globalReset_n(globalReset_n), .bus(ifa)
  );

  key_entry_sequencer #(
    .DATA_WIDTH(W), .MAX_DIGITS(3),
    .ASM_CYCLES(ASMC), .RUN_TIMEOUT(RUNT)
  ) dut3 (
    .clock(clock), .globalReset_n(globalReset_n), .bus(ifb)
  );

  typedef struct packed {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] oper;
    logic       asm_en;
    logic       cu;
    logic       sr;
    logic       err;
    logic [2:0] st;
  } obs_t;

  typedef struct {
    bit         v;
    logic [7:0] code;
    bit         done;
    obs_t       exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers, counted per key rules)
  int m_state, m_op1, m_op2, m_oper, m_n1, m_n2;
  int m_asm_left, m_age;
  bit m_cu, m_err, m_sr, h1, h2;

  function automatic obs_t mk_obs(int o1, int o2, int op, bit a,
                                  bit cu, bit sr, bit er, int st);
    obs_t o;
    o.op1 = 8'(o1); o.op2 = 8'(o2); o.oper = 8'(op);
    o.asm_en = a; o.cu = cu; o.sr = sr; o.err = er;
    o.st = 3'(st);
    return o;
  endfunction

  function automatic vec_t mk(bit v, int c, bit d, int o1, int o2,
                              int op, bit a, bit cu, bit sr,
                              bit er, int st);
    vec_t t;
    t.v = v; t.code = 8'(c); t.done = d;
    t.exp = mk_obs(o1, o2, op, a, cu, sr, er, st);
    return t;
  endfunction

  function automatic obs_t get_a();
    return mk_obs(int'(ifa.operand1), int'(ifa.operand2),
                  int'(ifa.operator), ifa.assembler_en, ifa.cu_en,
                  ifa.soft_reset, ifa.key_error, int'(ifa.seq_state));
  endfunction

  function automatic obs_t get_b();
    return mk_obs(int'(ifb.operand1), int'(ifb.operand2),
                  int'(ifb.operator), ifb.assembler_en, ifb.cu_en,
                  ifb.soft_reset, ifb.key_error, int'(ifb.seq_state));
  endfunction

  function automatic obs_t model_obs();
    return mk_obs(m_op1, m_op2, m_oper, m_asm_left > 0, m_cu,
                  m_sr, m_err, m_state);
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got op1=%0d op2=%0d oper=%0d asm=%0b cu=%0b sr=%0b err=%0b st=%0d | want op1=%0d op2=%0d oper=%0d asm=%0b cu=%0b sr=%0b err=%0b st=%0d",
        name, got.op1, got.op2, got.oper, got.asm_en, got.cu,
        got.sr, got.err, got.st, exp.op1, exp.op2, exp.oper,
        exp.asm_en, exp.cu, exp.sr, exp.err, exp.st);
    end
  endtask

  function automatic void model_clear();
    m_state = 0; m_op1 = 0; m_op2 = 0; m_oper = 0;
    m_n1 = 0; m_n2 = 0; m_asm_left = 0; m_age = 0;
    m_cu = 0; m_err = 0; m_sr = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    h1 = 0; h2 = 0;
  endfunction

  function automatic int sat(int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  function automatic void model_step(bit v, int c, bit done);
    bit rise;
    rise = h1 && !h2;
    h2 = h1;
    h1 = done;
    m_err = 0;
    m_sr = 0;
    if (v && c == 28) begin
      model_clear();
      m_sr = 1;
      return;
    end
    if (m_state == 2) begin
      m_err = v;
      m_asm_left--;
      if (m_asm_left == 0) m_state = 3;
      return;
    end
    if (m_state == 4) begin
      m_err = v;
      m_age++;
      if (rise) begin
        m_cu = 0; m_state = 0; m_n1 = 0; m_n2 = 0;
      end
`ifdef KEY_ENTRY_TIMEOUT_EN
      else if (m_age >= RUNT) begin
        m_cu = 0; m_err = 1; m_state = 0; m_n1 = 0; m_n2 = 0;
      end
`endif
      return;
    end
    if (!v) return;
    if (c <= 9) begin
      if (m_state == 3) m_err = 1;
      else if (m_state == 0) begin
        if (m_n1 >= MAXD) m_err = 1;
        else begin
          if (m_n1 == 0) begin
            m_op1 = 0; m_op2 = 0; m_oper = 0;
          end
          m_op1 = sat(m_op1 * 10 + c);
          m_n1++;
        end
      end else begin
        if (m_n2 >= MAXD) m_err = 1;
        else begin
          if (m_n2 == 0) m_op2 = 0;
          m_op2 = sat(m_op2 * 10 + c);
          m_n2++;
        end
      end
    end else if (c >= 20 && c <= 23) begin
      if (m_state == 0 && m_n1 > 0) begin
        m_oper = c; m_state = 1;
      end else if (m_state == 1 && m_n2 == 0) m_oper = c;
      else m_err = 1;
    end else if (c == 26) begin
      if (m_state == 1 && m_n2 > 0) begin
        m_state = 2; m_asm_left = ASMC;
      end else m_err = 1;
    end else if (c == 27) begin
      if (m_state == 3) begin
        m_state = 4; m_cu = 1; m_age = 0;
      end else m_err = 1;
    end else m_err = 1;
  endfunction

  task automatic tick(input bit v, input int code, input bit done);
    @(negedge clock);
    ifa.key_valid = v;
    ifa.key_code = 8'(code);
    ifa.cpu_done = done;
    ifb.key_valid = 1'b0;
    @(posedge clock);
    model_step(v, code, done);
    #1;
    check("model", get_a(), model_obs());
  endtask

  task automatic tick_b(input int code, input obs_t exp);
    @(negedge clock);
    ifb.key_valid = 1'b1;
    ifb.key_code = 8'(code);
    ifa.key_valid = 1'b0;
    @(posedge clock);
    model_step(0, 0, ifa.cpu_done);
    #1;
    check($sformatf("maxd3_key%0d", code), get_b(), exp);
  endtask

  vec_t tbl[$];

  initial begin
    obs_t zero;
    int r, code;
    bit v, rd;
    zero = mk_obs(0, 0, 0, 0, 0, 0, 0, 0);
    ifa.key_valid = 0; ifa.key_code = 0; ifa.cpu_done = 0;
    ifb.key_valid = 0; ifb.key_code = 0; ifb.cpu_done = 0;
    model_reset();

    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 12, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20, 0, 12, 0, 20, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3, 0, 12, 3, 20, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4, 0, 12, 34, 20, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 26, 0, 12, 34, 20, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12, 34, 20, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12, 34, 20, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12, 34, 20, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12, 34, 20, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 27, 0, 12, 34, 20, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 1, 12, 34, 20, 0, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 1, 12, 34, 20, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 12, 34, 20, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 99, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 99, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 99, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 28, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 20, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 26, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 21, 0, 5, 0, 21, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 27, 0, 5, 0, 21, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 22, 0, 5, 0, 22, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 26, 0, 5, 0, 22, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 7, 0, 5, 7, 22, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 26, 0, 5, 7, 22, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 5, 7, 22, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 28, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 24, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    #25;
    check("reset_a", get_a(), zero);
    check("reset_b", get_b(), zero);
    @(negedge clock);
    globalReset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].v, int'(tbl[i].code), tbl[i].done);
      check($sformatf("vec%0d", i), get_a(), tbl[i].exp);
    end

    tick_b(2, mk_obs(2, 0, 0, 0, 0, 0, 0, 0));
    tick_b(5, mk_obs(25, 0, 0, 0, 0, 0, 0, 0));
    tick_b(6, mk_obs(255, 0, 0, 0, 0, 0, 0, 0));
    tick_b(7, mk_obs(255, 0, 0, 0, 0, 0, 1, 0));

    tick(1, 3, 0); tick(1, 20, 0); tick(1, 4, 0); tick(1, 26, 0);
    tick(0, 0, 0);
    @(negedge clock);
    globalReset_n = 1'b0;
    #1;
    check("async_reset", get_a(), zero);
    model_reset();
    @(negedge clock);
    globalReset_n = 1'b1;

`ifdef KEY_ENTRY_TIMEOUT_EN
    tick(1, 1, 0); tick(1, 20, 0); tick(1, 2, 0); tick(1, 26, 0);
    repeat (ASMC) tick(0, 0, 0);
    tick(1, 27, 0);
    repeat (RUNT - 1) tick(0, 0, 0);
    tick(0, 0, 0);
    check("tmo_expire", get_a(), mk_obs(1, 2, 20, 0, 0, 0, 1, 0));
    tick(1, 1, 0); tick(1, 20, 0); tick(1, 2, 0); tick(1, 26, 0);
    repeat (ASMC) tick(0, 0, 0);
    tick(1, 27, 0);
    repeat (RUNT - 1) tick(0, 0, 0);
    tick(1, 28, 0);
    check("tmo_clear", get_a(), mk_obs(0, 0, 0, 0, 0, 1, 0, 0));
`endif

    rd = 0;
    for (int n = 0; n < 3000; n++) begin
      v = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      if (r < 50)      code = int'($urandom_range(0, 9));
      else if (r < 65) code = int'($urandom_range(20, 23));
      else if (r < 77) code = 26;
      else if (r < 89) code = 27;
      else if (r < 93) code = 28;
      else             code = int'($urandom_range(10, 255));
      if ($urandom_range(0, 7) == 0) rd = ~rd;
      tick(v, code, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_entry_sequencer.md
# key_entry_sequencer

Replaces the free-running delay-counter key handling in front of the calculator CPU with an event-driven parser. It consumes one strobed key code per keypress from the PS/2 keyboard decoder and assembles decimal operands and the operator. It then sequences the assembler-enable window, the control-unit run and the soft reset, and tracks completion through `cpu_done`. Its outputs drive the operand/operator inputs of the LCD terminal, assembler and control unit directly.

## Interface
- `DATA_WIDTH`, 8: operand width in bits.
- `MAX_DIGITS`, 2: maximum decimal digits accepted per operand.
- `ASM_CYCLES`, 4: width of the `assembler_en` high window, in clocks (≥1).
- `RUN_TIMEOUT`, 1000000: clocks allowed in RUN before abort (timeout build only).

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `globalReset_n`  in  1  reset, asynchronous, active-low.
- `key_valid`  in  1  one-cycle strobe, `key_code` valid.
- `key_code`  in  8  0–9 digit; 20–23 operator; 26 enter; 27 equals; 28 clear.
- `cpu_done`  in  1  control-unit finished, level.
- `operand1`, `operand2`  out  DATA_WIDTH  assembled operands.
- `operator`  out  8  latched operator code, 0 = none.
- `assembler_en`  out  1  assembler enable window.
- `cu_en`  out  1  control-unit enable, level.
- `soft_reset`  out  1  one-cycle soft reset pulse.
- `key_error`  out  1  one-cycle pulse on a rejected key or on timeout.
- `seq_state`  out  3  FSM state for 7-seg debug.

## Operation
- States: OP1=0, OP2=1, ASM=2, READY=3, RUN=4.
- Reset values: all outputs 0 and the state is OP1. Digit counters and the ASM/timeout counters are 0.
- Digit handling in OP1 or OP2:
  - If the active digit counter is below MAX_DIGITS, compute `acc = acc*10 + digit`.
  - The product is formed in DATA_WIDTH+4 bits. A result above 2^DATA_WIDTH−1 saturates to all-ones.
  - Increment the active digit counter.
  - If the counter is already at MAX_DIGITS, the digit is ignored and `key_error` pulses.
- Operator handling:
  - In OP1 with ≥1 digit: latch `operator` and go to OP2.
  - In OP1 with 0 digits: `key_error`.
  - In OP2 with 0 digits: replace `operator`.
  - In OP2 with ≥1 digit: `key_error`.
- Enter:
  - In OP2 with ≥1 digit: go to ASM and raise `assembler_en` for exactly ASM_CYCLES clocks, then go to READY. The operands are stable throughout, so the downstream negedge latch captures final values.
  - Elsewhere: `key_error`.
- Equals in READY: go to RUN and assert `cu_en`. In RUN, a rising edge of `cpu_done` drops `cu_en` and returns to OP1.
  - Operands and operator are retained for display.
  - The digit counters clear, so the next digit restarts `operand1` from 0 and zeroes `operand2`/`operator`.
- Clear (28) in any state:
  - `soft_reset` pulses for 1 cycle.
  - All registers return to reset values and the state goes to OP1.
  - Any `assembler_en` window in progress is truncated.
- Any other key code, or any non-clear key during ASM/RUN: `key_error` pulse, no state change.
- `key_valid` low: no action; `key_code` is ignored.

## Timing
- Every response appears on the registered outputs 1 clock after the `key_valid` cycle.
- `assembler_en` rises 1 clock after the enter strobe and falls ASM_CYCLES clocks later.
- A `cpu_done` rising edge is detected with 1 register stage. `cu_en` falls 2 clocks after the edge.
- If `cpu_done` is already high on entry to RUN, the block waits for a fresh 0→1 transition.
- A strobe in the same cycle as the `assembler_en` window end or a `cpu_done` detection:
  - clear wins over everything;
  - any other key is rejected.
- Asserting reset mid-window drops `assembler_en`/`cu_en` immediately (asynchronous).
- Back-to-back strobes on consecutive cycles are all processed.

## Configuration
- `KEY_ENTRY_TIMEOUT_EN` defined:
  - A RUN_TIMEOUT counter runs in RUN.
  - On expiry, `cu_en` drops, `key_error` pulses and the state goes to OP1.
  - A clear in the expiry cycle takes precedence (`soft_reset` pulses, no `key_error`).
- Undefined: no counter. RUN waits indefinitely for `cpu_done` or clear, and RUN_TIMEOUT is unused.

## Test plan
- Keys 1, 2, 20, 3, 4, 26 → `operand1`=12, `operand2`=34, `operator`=20, and `assembler_en` high exactly 4 clocks starting 1 clock after the enter strobe.
- After that sequence: key 27 → `cu_en`=1. `cpu_done` 0→1 → `cu_en`=0 two clocks later, `seq_state`=0, operands still 12/34.
- Keys 9, 9, 9 → `operand1`=99, `key_error` pulses on the third 9. A separate build with `MAX_DIGITS`=3, keys 2, 5, 6, 7 → 255 after 2, 5, 6; the fourth digit is rejected.
- Keys 20 in OP1, 26 in OP1, 27 in OP2 → `key_error` each time, `seq_state` unchanged.
- Key 28 during the ASM window (cycle 2) → `assembler_en` drops the next clock, `soft_reset` pulses 1 cycle, all outputs 0.
- Timeout build with `RUN_TIMEOUT`=16: enter RUN, hold `cpu_done`=0 → `cu_en` drops and `key_error` pulses 16 clocks later. A clear in that expiry cycle gives `soft_reset` only.
